// File: rtl/nibble_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter.
package nibble_tx_pkg;

  // FSM state encoding; also exported on the phase port for LED debug.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int   DATA_BITS = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity of a data word: plain XOR gives even parity, inverted gives odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word_i,
                                      input logic                 odd_i);
    return (^word_i) ^ odd_i;
  endfunction

endpackage

// File: rtl/nibble_hold_buf.sv
// One-word holding buffer: stores a nibble accepted mid-frame until the
// transmitter pops it at the end of the current frame.
module nibble_hold_buf
  import nibble_tx_pkg::*;
(
  input  logic                 clk_1Hz,
  input  logic                 clr,
  input  logic                 wr_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] d_i,
  output logic [DATA_BITS-1:0] word_o,
  output logic                 valid_o,
  output logic                 ready_o
);

  logic [DATA_BITS-1:0] word_q;
  logic                 valid_q;

  // Capture on write, release on pop; the two never coincide because a
  // write needs an empty buffer and a pop needs a full one.
  always_ff @(posedge clk_1Hz or posedge clr) begin
    if (clr) begin
      word_q  <= {DATA_BITS{1'b0}};
      valid_q <= 1'b0;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end else if (wr_i) begin
      word_q  <= d_i;
      valid_q <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign ready_o = ~valid_q;

endmodule

// File: rtl/nibble_serial_tx.sv
// Parallel-in, serial-out framed transmitter for 4-bit words on the 1 Hz
// tick domain. Frame: start, d[0..3] LSB first, optional parity, stop.
module nibble_serial_tx
  import nibble_tx_pkg::*;
#(
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_1Hz,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] d,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           phase
);

  localparam logic       PAR_EN   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);
  localparam logic [1:0] LAST_BIT = 2'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           cnt_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 accept_s;
  logic                 buf_wr_s;
  logic                 buf_pop_s;
  logic                 buf_valid_s;
  logic [DATA_BITS-1:0] buf_word_s;
  logic [DATA_BITS-1:0] next_word_d;

  nibble_hold_buf u_hold_buf (
    .clk_1Hz (clk_1Hz),
    .clr     (clr),
    .wr_i    (buf_wr_s),
    .pop_i   (buf_pop_s),
    .d_i     (d),
    .word_o  (buf_word_s),
    .valid_o (buf_valid_s),
    .ready_o (ready)
  );

  // Load steering: mid-frame loads go to the buffer, except at STOP where an
  // accepted load bypasses straight into the shifter; the buffered word wins.
  always_comb begin
    accept_s  = load & ready;
    buf_wr_s  = accept_s & busy_q & (state_q != ST_STOP);
    buf_pop_s = buf_valid_s & (state_q == ST_STOP);
    if (buf_valid_s) begin
      next_word_d = buf_word_s;
    end else begin
      next_word_d = d;
    end
  end

  // Frame sequencer, shifter and registered line outputs.
  always_ff @(posedge clk_1Hz or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      shift_q <= {DATA_BITS{1'b0}};
      cnt_q   <= 2'd0;
      par_q   <= 1'b0;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == ST_STOP);
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q <= ST_START;
            shift_q <= next_word_d;
            par_q   <= parity_bit(next_word_d, PAR_ODD);
            tx_q    <= START_BIT;
            busy_q  <= 1'b1;
          end else begin
            tx_q    <= STOP_BIT;
            busy_q  <= 1'b0;
          end
        end
        ST_START: begin
          state_q <= ST_DATA;
          tx_q    <= shift_q[0];
          shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
          cnt_q   <= 2'd0;
        end
        ST_DATA: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == LAST_BIT) begin
            if (PAR_EN) begin
              state_q <= ST_PARITY;
              tx_q    <= par_q;
            end else begin
              state_q <= ST_STOP;
              tx_q    <= STOP_BIT;
            end
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
        ST_PARITY: begin
          state_q <= ST_STOP;
          tx_q    <= STOP_BIT;
        end
        ST_STOP: begin
          if (buf_valid_s || accept_s) begin
            state_q <= ST_START;
            shift_q <= next_word_d;
            par_q   <= parity_bit(next_word_d, PAR_ODD);
            tx_q    <= START_BIT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            tx_q    <= STOP_BIT;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= STOP_BIT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign phase = state_q;

endmodule
